mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
// MEM-stage data-memory controller of the LC-3b pipeline; the producer of the
//   'enable' seen by the load-dependency stall logic.
// Drives the data-memory request/response handshake for LDR/LDB/LDI/STR/STB/STI.
// Performs the second access for indirect ops. Steers byte lanes.
// Holds pipeline_ready low until the access completes, then presents load data.
// PARAMETERS
// DATA_WIDTH  16  word width; fixed by the LC-3b ISA, do not override
// ADDR_WIDTH  16  byte address width
// PORTS
// clk             in   1   clock, all state on rising edge
// reset_n         in   1   asynchronous active-low reset
// valid           in   1   MEM-stage instruction is live
// ctrl            in   lc3b_control_word  uses mem_read, mem_write, mem_byte, mem_indirect
// addr            in   16  effective byte address from EX/MEM latch
// wdata           in   16  store source register value
// dmem_read       out  1   read strobe to data memory
// dmem_write      out  1   write strobe to data memory
// dmem_byte_en    out  2   lane enables {hi,lo}
// dmem_address    out  16  address to data memory
// dmem_wdata      out  16  write data, lane-steered
// dmem_resp       in   1   memory completion, one-cycle pulse
// dmem_rdata      in   16  read data, valid with dmem_resp
// pipeline_ready  out  1   1 = MEM stage may advance; drives load-dependency enable
// load_data       out  16  final load result, zero-extended for LDB
// BEHAVIOUR
// Reset: state IDLE, dmem_read=dmem_write=0, dmem_byte_en=2'b00, dmem_address=0,
//   dmem_wdata=0, load_data=0, pipeline_ready=1.
// FSM states (enum in package): IDLE, ACCESS, INDIRECT, DONE.
// IDLE: valid & (mem_read|mem_write) -> ACCESS; else stay, pipeline_ready=1.
//   Non-memory ops pass with zero added latency.
// ACCESS:
//   - Strobes asserted combinationally from state; no extra cycle.
//   - Indirect: first access is always a word read at {addr[15:1],1'b0}.
//   - Direct word op: address bit0 forced 0, byte_en=2'b11.
//   - Byte op: byte_en=addr[0]?2'b10:2'b01.
//   - STB wdata: {wdata[7:0],wdata[7:0]}.
//   - On dmem_resp:
//       indirect -> latch rdata as pointer -> INDIRECT;
//       otherwise -> capture load data -> DONE.
// INDIRECT: second access uses the latched pointer (bit0 forced 0).
//   - LDI reads a word; STI writes wdata with byte_en=2'b11.
//   - On dmem_resp -> DONE.
// DONE:
//   - pipeline_ready=1 for exactly one cycle; strobes low; load_data stable.
//   - Next state IDLE.
// pipeline_ready=0 in ACCESS and INDIRECT. Upstream holds ctrl/addr/wdata
//   stable while ready=0. Sampling them is legal only in IDLE.
// LDB extract: addr[0] ? {8'h00,rdata[15:8]} : {8'h00,rdata[7:0]}.
// load_data holds its value until the next completed load. Stores leave it unchanged.
// Timing:
//   - Latency = memory wait + 1 cycle (DONE) for direct ops.
//   - Indirect ops add the second access.
//   - No fixed limit on memory wait; strobes stay high until dmem_resp.
// Edge cases:
//   - dmem_resp outside ACCESS/INDIRECT: ignored.
//   - mem_read & mem_write both set: treated as read. Flagged by assertion.
//   - reset_n low mid-access: immediate IDLE; strobes drop same instant;
//     pointer and load_data cleared.
//   - valid=0 in IDLE: no request regardless of ctrl.
// STRUCTURE
// lc3b_types additions:
//   - lc3b_mem_state enum;
//   - ctrl fields mem_byte and mem_indirect, if absent.
// Sub-module mem_byte_lane (combinational):
//   - store steering + byte_en;
//   - LDB extract/zero-extend.
// Remainder (FSM, pointer register, load_data register) stays in this module.
// TESTING
// 1 LDR addr=16'h1003, resp after 3 waits, rdata=16'hBEEF:
//   dmem_address=16'h1002, byte_en=11, ready low 4 cyc, then load_data=16'hBEEF.
// 2 LDB addr=16'h2001, rdata=16'hA55A -> byte_en=10, load_data=16'h00A5.
//   Same with addr=16'h2000 -> 16'h005A.
// 3 STB addr=16'h3001, wdata=16'h12C4 -> dmem_write=1, byte_en=10,
//   dmem_wdata=16'hC4C4; load_data unchanged.
// 4 LDI addr=16'h4000:
//   - first rdata=16'h5001;
//   - second access at 16'h5000, rdata=16'h0042;
//   - load_data=16'h0042; ready low through both accesses.
// 5 STI with immediate resp: two accesses, second is write at pointer.
//   - ready high exactly one cycle in DONE.
// 6 Reset and gating:
//   - reset_n low while in INDIRECT -> strobes 0 immediately, state IDLE,
//     ready=1, load_data=0;
//   - spurious dmem_resp in IDLE causes no change.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types for the LC-3b MEM-stage data-memory controller: control-word
// memory fields, controller state encoding and an address helper.
package mem_access_unit_pkg;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic mem_byte;
    logic mem_indirect;
  } lc3b_control_word;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StIndirect,
    StDone
  } lc3b_mem_state;

  function automatic logic [15:0] word_align(input logic [15:0] a);
    return {a[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Combinational byte-lane steering: store replication, lane enables and
// zero-extended byte extraction for LDB.
module mem_byte_lane (
  input  logic        addr_lsb,
  input  logic        mem_byte,
  input  logic [15:0] wdata,
  input  logic [15:0] rdata,
  output logic [1:0]  byte_en,
  output logic [15:0] store_data,
  output logic [15:0] load_ext
);

  always_comb begin
    byte_en    = 2'b11;
    store_data = wdata;
    load_ext   = rdata;
    if (mem_byte) begin
      byte_en    = addr_lsb ? 2'b10 : 2'b01;
      // Memory picks the lane from byte_en, so drive the byte on both halves.
      store_data = {wdata[7:0], wdata[7:0]};
      load_ext   = addr_lsb ? {8'h00, rdata[15:8]} : {8'h00, rdata[7:0]};
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// LC-3b MEM-stage data-memory controller: runs the request/response handshake,
// the second access of indirect ops, and holds pipeline_ready low meanwhile.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  valid,
  input  lc3b_control_word      ctrl,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  dmem_read,
  output logic                  dmem_write,
  output logic [1:0]            dmem_byte_en,
  output logic [ADDR_WIDTH-1:0] dmem_address,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_resp,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  pipeline_ready,
  output logic [DATA_WIDTH-1:0] load_data
);

  lc3b_mem_state   state_q, state_d;
  logic [15:0]     ptr_q, ptr_d;
  logic [15:0]     load_q, load_d;
  logic            is_read, is_write;
  logic [1:0]      lane_be;
  logic [15:0]     lane_wdata, lane_load;

  // A conflicting read+write decode is serviced as a read.
  assign is_read   = ctrl.mem_read;
  assign is_write  = ctrl.mem_write & ~ctrl.mem_read;
  assign load_data = load_q;

  mem_byte_lane u_byte_lane (
    .addr_lsb   (addr[0]),
    .mem_byte   (ctrl.mem_byte),
    .wdata      (wdata),
    .rdata      (dmem_rdata),
    .byte_en    (lane_be),
    .store_data (lane_wdata),
    .load_ext   (lane_load)
  );

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    load_d         = load_q;
    dmem_read      = 1'b0;
    dmem_write     = 1'b0;
    dmem_byte_en   = 2'b00;
    dmem_address   = '0;
    dmem_wdata     = '0;
    pipeline_ready = 1'b0;
    case (state_q)
      StIdle: begin
        pipeline_ready = 1'b1;
        if (valid && (ctrl.mem_read || ctrl.mem_write)) state_d = StAccess;
      end
      StAccess: begin
        if (ctrl.mem_indirect) begin
          dmem_read    = 1'b1;
          dmem_address = word_align(addr);
          dmem_byte_en = 2'b11;
          if (dmem_resp) begin
            ptr_d   = dmem_rdata;
            state_d = StIndirect;
          end
        end else begin
          dmem_read    = is_read;
          dmem_write   = is_write;
          dmem_address = ctrl.mem_byte ? addr : word_align(addr);
          dmem_byte_en = lane_be;
          if (is_write) dmem_wdata = lane_wdata;
          if (dmem_resp) begin
            if (is_read) load_d = lane_load;
            state_d = StDone;
          end
        end
      end
      StIndirect: begin
        dmem_read    = is_read;
        dmem_write   = is_write;
        dmem_address = word_align(ptr_q);
        dmem_byte_en = 2'b11;
        if (is_write) dmem_wdata = wdata;
        if (dmem_resp) begin
          if (is_read) load_d = dmem_rdata;
          state_d = StDone;
        end
      end
      StDone: begin
        pipeline_ready = 1'b1;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      load_q  <= load_d;
    end
  end

`ifndef SYNTHESIS
  rw_exclusive_a: assert property (@(posedge clk) disable iff (!reset_n)
    !(valid && ctrl.mem_read && ctrl.mem_write));
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a word-array memory model predicts
// every access and load result; a responder and a monitor check them.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             valid = 1'b0;
  lc3b_control_word ctrl = '0;
  logic [15:0]      addr = '0, wdata = '0;
  logic             dmem_read, dmem_write, dmem_resp, pipeline_ready;
  logic [1:0]       dmem_byte_en;
  logic [15:0]      dmem_address, dmem_wdata, dmem_rdata, load_data;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .valid          (valid),
    .ctrl           (ctrl),
    .addr           (addr),
    .wdata          (wdata),
    .dmem_read      (dmem_read),
    .dmem_write     (dmem_write),
    .dmem_byte_en   (dmem_byte_en),
    .dmem_address   (dmem_address),
    .dmem_wdata     (dmem_wdata),
    .dmem_resp      (dmem_resp),
    .dmem_rdata     (dmem_rdata),
    .pipeline_ready (pipeline_ready),
    .load_data      (load_data)
  );

  typedef struct { bit rd; bit wr; logic [15:0] a; logic [1:0] be; logic [15:0] wd; } acc_t;
  typedef struct { logic [15:0] load; int low; } exp_t;

  acc_t        acc_q[$];
  exp_t        exp_q[$];
  int          wait_q[$];
  logic [15:0] ref_mem[int];
  logic [15:0] sim_mem[int];
  int          n_vec = 0, n_bad = 0, done_cnt = 0;
  bit          spurious = 1'b0;
  logic [15:0] ref_load = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_word(input int w);
    logic [15:0] x = 16'(w);
    return {x[7:0], x[15:8]} ^ 16'h3C96;
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    int w = int'(a[15:1]);
    return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
  endfunction

  function automatic logic [15:0] sim_rd(input logic [15:0] a);
    int w = int'(a[15:1]);
    return sim_mem.exists(w) ? sim_mem[w] : init_word(w);
  endfunction

  function automatic acc_t mk_acc(input bit rd, input bit wr, input logic [15:0] a,
                                  input logic [1:0] be, input logic [15:0] wd);
    acc_t x;
    x.rd = rd; x.wr = wr; x.a = a; x.be = be; x.wd = wd;
    return x;
  endfunction

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    ref_mem[int'(a[15:1])] = d;
    sim_mem[int'(a[15:1])] = d;
  endtask

  // Memory responder: per-access wait counts come from wait_q.
  initial begin : responder
    int cur_wait = 0, wait_cnt = 0;
    bit have_wait = 1'b0;
    acc_t e;
    logic [15:0] word;
    dmem_resp  = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(negedge clk);
      dmem_resp = 1'b0;
      if (!reset_n) begin
        have_wait = 1'b0;
        wait_cnt  = 0;
      end else if (dmem_read || dmem_write) begin
        if (!have_wait) begin
          cur_wait  = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
          have_wait = 1'b1;
          wait_cnt  = 0;
        end
        if (wait_cnt < cur_wait) begin
          wait_cnt++;
        end else begin
          have_wait = 1'b0;
          if (acc_q.size() == 0) begin
            check("unexpected_access", 32'(dmem_address), 32'hFFFF_FFFF);
          end else begin
            e = acc_q.pop_front();
            check("acc_kind", 32'({dmem_read, dmem_write}), 32'({e.rd, e.wr}));
            check("acc_addr", 32'(dmem_address), 32'(e.a));
            check("acc_byte_en", 32'(dmem_byte_en), 32'(e.be));
            if (e.wr) check("acc_wdata", 32'(dmem_wdata), 32'(e.wd));
          end
          word = sim_rd(dmem_address);
          if (dmem_write) begin
            if (dmem_byte_en[0]) word[7:0] = dmem_wdata[7:0];
            if (dmem_byte_en[1]) word[15:8] = dmem_wdata[15:8];
            sim_mem[int'(dmem_address[15:1])] = word;
          end
          dmem_rdata = dmem_read ? word : 16'h0;
          dmem_resp  = 1'b1;
        end
      end else if (spurious) begin
        spurious   = 1'b0;
        dmem_rdata = 16'hDEAD;
        dmem_resp  = 1'b1;
      end
    end
  end

  // Completion monitor: a ready-high cycle after a ready-low run is DONE.
  initial begin : monitor
    int low = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        low = 0;
      end else if (!pipeline_ready) begin
        low++;
      end else if (low > 0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", 32'(low), 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("load_data", 32'(load_data), 32'(e.load));
          check("ready_low_cycles", 32'(low), 32'(e.low));
          check("done_strobes", 32'({dmem_read, dmem_write}), 32'h0);
        end
        low = 0;
        done_cnt++;
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_strobes", 32'({dmem_read, dmem_write}), 32'h0);
    check("rst_byte_en", 32'(dmem_byte_en), 32'h0);
    check("rst_addr_wdata", {dmem_address, dmem_wdata}, 32'h0);
    check("rst_ready", 32'(pipeline_ready), 32'h1);
    check("rst_load_data", 32'(load_data), 32'h0);
    valid = 1'b0;
    @(negedge clk); #1;
    acc_q.delete();
    exp_q.delete();
    wait_q.delete();
    ref_load = '0;
    @(negedge clk); #1;
    reset_n = 1'b1;
  endtask

  // op: 0 LDR, 1 LDB, 2 STR, 3 STB, 4 LDI, 5 STI, 6 valid non-memory, 7 invalid load
  task automatic issue(input int op, input logic [15:0] a, input logic [15:0] wd,
                       input int w1, input int w2, input bit abort);
    lc3b_control_word c;
    exp_t e;
    logic [15:0] p, word;
    int start;
    bit ok;
    c.mem_read     = (op == 0 || op == 1 || op == 4 || op == 7);
    c.mem_write    = (op == 2 || op == 3 || op == 5);
    c.mem_byte     = (op == 1 || op == 3);
    c.mem_indirect = (op == 4 || op == 5);
    ctrl  = c;
    addr  = a;
    wdata = wd;
    if (op >= 6) begin
      valid = (op == 6);
      for (int i = 0; i < 2; i++) begin
        @(negedge clk); #1;
        check("idle_no_strobe", 32'({dmem_read, dmem_write}), 32'h0);
        check("idle_ready", 32'(pipeline_ready), 32'h1);
      end
      valid = 1'b0;
      return;
    end
    p = '0;
    e.low = w1 + 1;
    wait_q.push_back(w1);
    case (op)
      0: begin
        acc_q.push_back(mk_acc(1, 0, word_align(a), 2'b11, 16'h0));
        ref_load = ref_rd(a);
      end
      1: begin
        word = ref_rd(a);
        acc_q.push_back(mk_acc(1, 0, a, a[0] ? 2'b10 : 2'b01, 16'h0));
        ref_load = a[0] ? {8'h00, word[15:8]} : {8'h00, word[7:0]};
      end
      2: begin
        acc_q.push_back(mk_acc(0, 1, word_align(a), 2'b11, wd));
        ref_mem[int'(a[15:1])] = wd;
      end
      3: begin
        acc_q.push_back(mk_acc(0, 1, a, a[0] ? 2'b10 : 2'b01, {wd[7:0], wd[7:0]}));
        word = ref_rd(a);
        if (a[0]) word[15:8] = wd[7:0];
        else      word[7:0]  = wd[7:0];
        ref_mem[int'(a[15:1])] = word;
      end
      default: begin
        p = ref_rd(a);
        e.low += w2 + 1;
        wait_q.push_back(w2);
        acc_q.push_back(mk_acc(1, 0, word_align(a), 2'b11, 16'h0));
        if (op == 4) begin
          acc_q.push_back(mk_acc(1, 0, word_align(p), 2'b11, 16'h0));
          ref_load = ref_rd(p);
        end else begin
          acc_q.push_back(mk_acc(0, 1, word_align(p), 2'b11, wd));
          ref_mem[int'(p[15:1])] = wd;
        end
      end
    endcase
    e.load = ref_load;
    exp_q.push_back(e);
    valid = 1'b1;
    start = done_cnt;
    ok    = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (abort ? (dmem_read && dmem_address == word_align(p)) : (done_cnt != start)) begin
        ok = 1'b1;
        break;
      end
    end
    valid = 1'b0;
    check(abort ? "reach_indirect" : "completion", 32'(ok), 32'h1);
    if (!ok || abort) do_reset();
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    do_reset();
    // LDR with three wait cycles
    preload(16'h1002, 16'hBEEF);
    issue(0, 16'h1003, 16'h0, 3, 0, 0);
    check("t1_load", 32'(load_data), 32'h0000_BEEF);
    // LDB both lanes
    preload(16'h2000, 16'hA55A);
    issue(1, 16'h2001, 16'h0, 1, 0, 0);
    check("t2_ldb_hi", 32'(load_data), 32'h0000_00A5);
    issue(1, 16'h2000, 16'h0, 0, 0, 0);
    check("t2_ldb_lo", 32'(load_data), 32'h0000_005A);
    // STB leaves load_data alone
    issue(3, 16'h3001, 16'h12C4, 2, 0, 0);
    check("t3_load_kept", 32'(load_data), 32'h0000_005A);
    // LDI through pointer
    preload(16'h4000, 16'h5001);
    preload(16'h5000, 16'h0042);
    issue(4, 16'h4000, 16'h0, 1, 2, 0);
    check("t4_ldi", 32'(load_data), 32'h0000_0042);
    // STI with immediate responses
    preload(16'h4200, 16'h6003);
    issue(5, 16'h4200, 16'h7777, 0, 0, 0);
    check("t5_sti_mem", 32'(sim_rd(16'h6002)), 32'h0000_7777);
    // Reset while the indirect access is outstanding
    preload(16'h4100, 16'h5101);
    issue(4, 16'h4100, 16'h0, 0, 8, 1);
    // Spurious response in IDLE
    issue(0, 16'h1002, 16'h0, 0, 0, 0);
    spurious = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("spur_load", 32'(load_data), 32'h0000_BEEF);
    check("spur_idle", 32'({pipeline_ready, dmem_read, dmem_write}), 32'h4);
    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      logic [15:0] ra;
      ra = {8'h60 + 8'($urandom_range(0, 3)), 8'($urandom_range(0, 255))};
      issue(int'($urandom_range(0, 7)), ra, 16'($urandom),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
    end
    repeat (3) @(negedge clk);
    check("queues_drained", 32'(acc_q.size() + exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
